// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets two requesters share one
// external combinational ALU. Each operation takes IDLE -> EXEC -> RESP.
// An accepted operation is latched, driven to the ALU for one cycle, and
// the captured result is held for the owner until it takes the response.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_z,
  output logic        rsp_n,
  output logic        rsp_err,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_z,
  input  logic        alu_n
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_IDLE = 3'b111;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic        r_owner;
  logic [2:0]  r_alu_opcode;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [1:0]  r_rsp_valid;
  logic [31:0] r_rsp_result;
  logic        r_rsp_z;
  logic        r_rsp_n;
  logic        r_rsp_err;
  logic [1:0]  w_grant;
  logic        w_accept;
  logic        w_sel;
  logic        w_rsp_done;

  // Only the four defined opcodes reach the ALU result path; the rest
  // produce an error response.
  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      3'b100, 3'b010, 3'b001, 3'b111: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  endfunction

  // Arbitration: grant is only offered in IDLE; a tie goes to the requester
  // that did not win last time, a lone requester always wins.
  always_comb begin
    w_grant = 2'b00;
    if (r_state == ST_IDLE) begin
      case (req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end else begin
      w_grant = 2'b00;
    end
  end

  assign w_accept   = |w_grant;
  assign w_sel      = w_grant[1];
  // Only the owner's rsp_ready can retire the response.
  assign w_rsp_done = (r_state == ST_RESP) && rsp_ready[r_owner];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: begin
        if (w_rsp_done) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operation latch: the ALU drive registers double as the operation
  // storage, loaded on accept and returned to idle once EXEC ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_alu_opcode <= OP_IDLE;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
    end else if (w_accept) begin
      r_last_grant <= w_sel;
      r_owner      <= w_sel;
      r_alu_opcode <= w_sel ? req_op1 : req_op0;
      r_alu_a      <= w_sel ? req_a1 : req_a0;
      r_alu_b      <= w_sel ? req_b1 : req_b0;
    end else if (r_state == ST_EXEC) begin
      r_alu_opcode <= OP_IDLE;
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
    end
  end

  // Response capture at the end of EXEC, held until the owner takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid  <= 2'b00;
      r_rsp_result <= 32'd0;
      r_rsp_z      <= 1'b0;
      r_rsp_n      <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
      if (op_legal(r_alu_opcode)) begin
        r_rsp_result <= alu_out;
        r_rsp_z      <= alu_z;
        r_rsp_n      <= alu_n;
        r_rsp_err    <= 1'b0;
      end else begin
        r_rsp_result <= 32'd0;
        r_rsp_z      <= 1'b0;
        r_rsp_n      <= 1'b0;
        r_rsp_err    <= 1'b1;
      end
    end else if (w_rsp_done) begin
      r_rsp_valid <= 2'b00;
    end
  end

  assign req_ready  = w_grant;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_z      = r_rsp_z;
  assign rsp_n      = r_rsp_n;
  assign rsp_err    = r_rsp_err;
  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. The bench supplies the external ALU
// and can corrupt its outputs to show the arbiter ignores them when it should.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_op0;
  logic [2:0]  req_op1;
  logic [31:0] req_a0;
  logic [31:0] req_b0;
  logic [31:0] req_a1;
  logic [31:0] req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_z;
  logic        rsp_n;
  logic        rsp_err;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_z;
  logic        alu_n;
  logic        alu_corrupt;
  logic [31:0] m_out;

  int n_checks = 0;
  int n_pass   = 0;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_z      (rsp_z),
    .rsp_n      (rsp_n),
    .rsp_err    (rsp_err),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_z      (alu_z),
    .alu_n      (alu_n)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External ALU model with optional corruption of its outputs.
  always_comb begin
    m_out = 32'd0;
    case (alu_opcode)
      3'b100:  m_out = alu_a + alu_b;
      3'b010:  m_out = 32'd0 - alu_b;
      3'b001:  m_out = alu_b - alu_a;
      3'b111:  m_out = alu_a;
      default: m_out = 32'h0BAD_0BAD;
    endcase
    if (alu_corrupt) begin
      alu_out = 32'hDEAD_BEEF;
      alu_z   = 1'b1;
      alu_n   = 1'b1;
    end else begin
      alu_out = m_out;
      alu_z   = (m_out == 32'd0);
      alu_n   = m_out[31];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation from a single requester with full checking.
  task automatic run_op(input logic who, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_res, input logic e_z,
                        input logic e_n, input logic e_err, input string tag);
    logic [1:0] bitv;
    bitv = who ? 2'b10 : 2'b01;
    if (who) begin
      req_op1 = op; req_a1 = a; req_b1 = b;
    end else begin
      req_op0 = op; req_a0 = a; req_b0 = b;
    end
    req_valid = bitv;
    #1;
    check_eq({tag, "_ready"}, {30'd0, req_ready}, {30'd0, bitv});
    tick();
    check_eq({tag, "_exec_op"}, {29'd0, alu_opcode}, {29'd0, op});
    check_eq({tag, "_exec_a"}, alu_a, a);
    check_eq({tag, "_exec_b"}, alu_b, b);
    check_eq({tag, "_exec_noready"}, {30'd0, req_ready}, 32'd0);
    check_eq({tag, "_exec_novalid"}, {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b00;
    tick();
    check_eq({tag, "_rsp_valid"}, {30'd0, rsp_valid}, {30'd0, bitv});
    check_eq({tag, "_result"}, rsp_result, e_res);
    check_eq({tag, "_flags"}, {29'd0, rsp_z, rsp_n, rsp_err}, {29'd0, e_z, e_n, e_err});
    check_eq({tag, "_resp_aluidle"}, {29'd0, alu_opcode}, 32'd7);
    rsp_ready = bitv;
    tick();
    rsp_ready = 2'b00;
    check_eq({tag, "_done"}, {30'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00; alu_corrupt = 1'b0;
    req_op0 = 3'b111; req_op1 = 3'b111;
    req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    tick();
    tick();
    // Reset state.
    check_eq("rst_ready", {30'd0, req_ready}, 32'd0);
    check_eq("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check_eq("rst_result", rsp_result, 32'd0);
    check_eq("rst_flags", {29'd0, rsp_z, rsp_n, rsp_err}, 32'd0);
    check_eq("rst_alu_op", {29'd0, alu_opcode}, 32'd7);
    check_eq("rst_alu_ab", alu_a | alu_b, 32'd0);
    rst = 1'b0;
    tick();

    // Basic ops.
    run_op(1'b0, 3'b100, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0, "add");
    run_op(1'b1, 3'b001, 32'd9, 32'd4, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0, "sub");
    run_op(1'b0, 3'b111, 32'd0, 32'd55, 32'd0, 1'b1, 1'b0, 1'b0, "passz");
    run_op(1'b1, 3'b010, 32'd1, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, "neg");
    run_op(1'b0, 3'b100, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0, 1'b0, "wrap");

    // Round-robin with both requesters valid continuously after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_op0 = 3'b100; req_a0 = 32'd1; req_b0 = 32'd2;
    req_op1 = 3'b111; req_a1 = 32'h8000_0000; req_b1 = 32'd0;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("rr_ready", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      tick();
      check_eq("rr_rsp_valid", {30'd0, rsp_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
      check_eq("rr_result", rsp_result, (k % 2 == 0) ? 32'd3 : 32'h8000_0000);
      rsp_ready = 2'b11;
      tick();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;

    // Backpressure: payload holds and nothing is accepted.
    req_op0 = 3'b100; req_a0 = 32'd10; req_b0 = 32'd20;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    for (int k = 0; k < 5; k++) begin
      alu_corrupt = ~alu_corrupt;
      req_valid = 2'b11;
      req_op0 = 3'(k); req_a0 = 32'(k * 3); req_op1 = 3'(k + 1); req_a1 = 32'(k);
      tick();
      check_eq("bp_result", rsp_result, 32'd30);
      check_eq("bp_valid", {30'd0, rsp_valid}, 32'd1);
      check_eq("bp_noready", {30'd0, req_ready}, 32'd0);
      check_eq("bp_flags", {29'd0, rsp_z, rsp_n, rsp_err}, 32'd0);
    end
    alu_corrupt = 1'b0;
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check_eq("bp_done", {30'd0, rsp_valid}, 32'd0);
    check_eq("bp_idle_ready", {30'd0, req_ready}, 32'd2);
    req_valid = 2'b00;
    tick();

    // Illegal opcode with corrupted ALU; non-owner rsp_ready ignored.
    req_op0 = 3'b110; req_a0 = 32'd3; req_b0 = 32'd4;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    alu_corrupt = 1'b1;
    tick();
    alu_corrupt = 1'b0;
    check_eq("ill_result", rsp_result, 32'd0);
    check_eq("ill_flags", {29'd0, rsp_z, rsp_n, rsp_err}, 32'd1);
    rsp_ready = 2'b10;
    tick();
    tick();
    check_eq("ill_nonowner", {30'd0, rsp_valid}, 32'd1);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check_eq("ill_done", {30'd0, rsp_valid}, 32'd0);

    // Reset in EXEC abandons the operation and restores last_grant.
    req_op1 = 3'b100; req_a1 = 32'd1; req_b1 = 32'd1;
    req_valid = 2'b10;
    tick();
    check_eq("rexec_in_exec", {29'd0, alu_opcode}, 32'd4);
    req_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rexec_alu", {29'd0, alu_opcode}, 32'd7);
    for (int k = 0; k < 3; k++) begin
      check_eq("rexec_novalid", {30'd0, rsp_valid}, 32'd0);
      tick();
    end
    req_valid = 2'b11;
    #1;
    check_eq("rexec_tie", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
